// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error accumulator.
package mul_err_pkg;

   localparam int unsigned DEF_OP_W = 6;
   localparam int unsigned P_W      = 2 * DEF_OP_W;
   localparam int unsigned CNT_W    = 2 * DEF_OP_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Add two values and clamp the result at 2**sum_w - 1.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned sum_w);
      logic [64:0] s;
      logic [64:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << sum_w) - 65'd1;
      return (s > lim) ? lim[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/mul_err_dist.sv
// S2 datapath: exact unsigned product and its absolute distance from the approximate product.
module mul_err_dist #(
   parameter int unsigned OP_W = 6
) (
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   input  logic [2*OP_W-1:0] approx_i,
   output logic [2*OP_W-1:0] exact_o,
   output logic [2*OP_W-1:0] ed_o
);

   logic [2*OP_W-1:0] prod;

   always_comb begin
      prod    = (2*OP_W)'(a_i) * (2*OP_W)'(b_i);
      exact_o = prod;
      ed_o    = (prod >= approx_i) ? (prod - approx_i) : (approx_i - prod);
   end

endmodule

// File: rtl/mul_err_accum.sv
// Error-metric accumulator for 6x6 approximate multipliers: 2-stage pipeline feeding
// count / sum / max error-distance registers, sequenced by a run FSM.
module mul_err_accum
   import mul_err_pkg::*;
#(
   parameter int unsigned OP_W      = 6,
   parameter int unsigned N_SAMPLES = 4096,
   parameter int unsigned SUM_W     = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   input  logic [2*OP_W-1:0] approx_p,
   output logic              busy,
   output logic              done,
   output logic [2*OP_W:0]   n_err,
   output logic [SUM_W-1:0]  sum_ed,
   output logic [2*OP_W-1:0] max_ed,
   output logic [2*OP_W:0]   n_seen
);

   localparam int unsigned PW = 2 * OP_W;
   localparam int unsigned CW = 2 * OP_W + 1;
   localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES);

   state_t          state_q, state_d;
   logic [CW-1:0]   issued_q, issued_d;
   logic            done_q, done_d;
   logic            clear;
   logic            accept;

   logic [OP_W-1:0] a_s1_q, b_s1_q;
   logic [PW-1:0]   p_s1_q;
   logic            v1_q;

   logic [PW-1:0]   exact_w, ed_w;
   logic [PW-1:0]   ed_s2_q;
   logic            err_s2_q;
   logic            v2_q;

   logic [CW-1:0]    n_seen_q, n_seen_d;
   logic [CW-1:0]    n_err_q, n_err_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [PW-1:0]    max_q, max_d;

   assign in_ready = (state_q == ST_RUN) && (issued_q < N_LAST);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done     = done_q;
   assign n_seen   = n_seen_q;
   assign n_err    = n_err_q;
   assign sum_ed   = sum_q;
   assign max_ed   = max_q;

   always_comb begin
      state_d  = state_q;
      issued_d = issued_q;
      clear    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               issued_d = '0;
               clear    = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept) issued_d = issued_q + CW'(1);
            if (issued_q == N_LAST) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (n_seen_q == N_LAST) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   mul_err_dist #(.OP_W(OP_W)) u_dist (
      .a_i      (a_s1_q),
      .b_i      (b_s1_q),
      .approx_i (p_s1_q),
      .exact_o  (exact_w),
      .ed_o     (ed_w)
   );

   // Metrics only move on a valid S2 result; start clears them instead.
   always_comb begin
      n_seen_d = n_seen_q;
      n_err_d  = n_err_q;
      sum_d    = sum_q;
      max_d    = max_q;
      if (clear) begin
         n_seen_d = '0;
         n_err_d  = '0;
         sum_d    = '0;
         max_d    = '0;
      end else if (v2_q) begin
         n_seen_d = n_seen_q + CW'(1);
         if (err_s2_q) n_err_d = n_err_q + CW'(1);
         sum_d = SUM_W'(sat_add(64'(sum_q), 64'(ed_s2_q), SUM_W));
         if (ed_s2_q > max_q) max_d = ed_s2_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         issued_q <= '0;
         done_q   <= 1'b0;
         a_s1_q   <= '0;
         b_s1_q   <= '0;
         p_s1_q   <= '0;
         v1_q     <= 1'b0;
         ed_s2_q  <= '0;
         err_s2_q <= 1'b0;
         v2_q     <= 1'b0;
         n_seen_q <= '0;
         n_err_q  <= '0;
         sum_q    <= '0;
         max_q    <= '0;
      end else begin
         state_q  <= state_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         a_s1_q   <= in_a;
         b_s1_q   <= in_b;
         p_s1_q   <= approx_p;
         v1_q     <= accept;
         ed_s2_q  <= ed_w;
         err_s2_q <= (exact_w != p_s1_q);
         v2_q     <= v1_q;
         n_seen_q <= n_seen_d;
         n_err_q  <= n_err_d;
         sum_q    <= sum_d;
         max_q    <= max_d;
      end
   end

endmodule

// File: tb/tb_mul_err_accum.sv
// Self-checking bench: scoreboarded exhaustive runs, table-driven distance checks, corner sequences.
module tb_mul_err_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [5:0]  in_a = '0, in_b = '0;
   logic [11:0] approx_p = '0;

   logic start_a = 1'b0, start_n = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic rdy_a, rdy_n, rdy_b, rdy_c;
   logic busy_a, busy_n, busy_b, busy_c;
   logic done_a, done_n, done_b, done_c;
   logic [12:0] err_a, err_n, err_b, err_c;
   logic [12:0] seen_a, seen_n, seen_b, seen_c;
   logic [23:0] sum_a, sum_n, sum_b;
   logic [11:0] sum_c;
   logic [11:0] max_a, max_n, max_b, max_c;

   logic [5:0]  d_a, d_b;
   logic [11:0] d_p, d_exact, d_ed;

   int tests = 0;
   int fails = 0;
   int done_cnt_a = 0;

   typedef struct {
      logic [12:0] seen;
      logic [12:0] err;
      logic [23:0] sum;
      logic [11:0] max;
   } met_t;

   typedef struct {
      logic [5:0]  a;
      logic [5:0]  b;
      logic [11:0] p;
      logic [11:0] exact;
      logic [11:0] ed;
   } dvec_t;

   met_t model;
   met_t sb[$];

   always #5 clk = ~clk;

   mul_err_accum u_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
      .in_a(in_a), .in_b(in_b), .approx_p(approx_p), .busy(busy_a), .done(done_a),
      .n_err(err_a), .sum_ed(sum_a), .max_ed(max_a), .n_seen(seen_a));

   mul_err_accum #(.N_SAMPLES(1)) u_n (
      .clk(clk), .rst(rst), .start(start_n), .in_valid(in_valid), .in_ready(rdy_n),
      .in_a(in_a), .in_b(in_b), .approx_p(approx_p), .busy(busy_n), .done(done_n),
      .n_err(err_n), .sum_ed(sum_n), .max_ed(max_n), .n_seen(seen_n));

   mul_err_accum #(.N_SAMPLES(4)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
      .in_a(in_a), .in_b(in_b), .approx_p(approx_p), .busy(busy_b), .done(done_b),
      .n_err(err_b), .sum_ed(sum_b), .max_ed(max_b), .n_seen(seen_b));

   mul_err_accum #(.N_SAMPLES(2), .SUM_W(12)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .in_ready(rdy_c),
      .in_a(in_a), .in_b(in_b), .approx_p(approx_p), .busy(busy_c), .done(done_c),
      .n_err(err_c), .sum_ed(sum_c), .max_ed(max_c), .n_seen(seen_c));

   mul_err_dist #(.OP_W(6)) u_dist (
      .a_i(d_a), .b_i(d_b), .approx_i(d_p), .exact_o(d_exact), .ed_o(d_ed));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic logic ready_of(input int sel);
      case (sel)
         0:       return rdy_a;
         1:       return rdy_n;
         2:       return rdy_b;
         default: return rdy_c;
      endcase
   endfunction

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return done_a;
         1:       return done_n;
         2:       return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic model_push(input logic [5:0] a, input logic [5:0] b, input logic [11:0] p);
      logic [11:0] ex, ed;
      logic [24:0] s;
      ex = 12'(a) * 12'(b);
      ed = (ex >= p) ? ex - p : p - ex;
      model.seen = model.seen + 13'd1;
      if (ed != 0) model.err = model.err + 13'd1;
      s = {1'b0, model.sum} + 25'(ed);
      model.sum = (s > 25'h0FF_FFFF) ? 24'hFF_FFFF : s[23:0];
      if (ed > model.max) model.max = ed;
      sb.push_back(model);
   endtask

   task automatic model_clear();
      model.seen = '0;
      model.err  = '0;
      model.sum  = '0;
      model.max  = '0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic drive(input int sel, input logic [5:0] a, input logic [5:0] b,
                        input logic [11:0] p);
      int unsigned guard;
      guard = 0;
      in_a = a; in_b = b; approx_p = p; in_valid = 1'b1;
      while (!ready_of(sel) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!ready_of(sel)) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", guard);
      end else if (sel == 0) begin
         model_push(a, b, p);
      end
      @(negedge clk);
   endtask

   task automatic pulse(input int sel);
      case (sel)
         0:       start_a = 1'b1;
         1:       start_n = 1'b1;
         2:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0; start_n = 1'b0; start_b = 1'b0; start_c = 1'b0;
   endtask

   task automatic wait_done(input int sel, input int unsigned budget);
      int unsigned n;
      n = 0;
      while (!done_of(sel) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", 32'(done_of(sel)), 32'd1);
   endtask

   task automatic exhaustive_run();
      model_clear();
      done_cnt_a = 0;
      pulse(0);
      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++)
            drive(0, 6'(a), 6'(b), 12'(a * b));
      in_valid = 1'b0;
      wait_done(0, 20);
      check("ex_n_seen", 32'(seen_a), 32'd4096);
      check("ex_n_err", 32'(err_a), 32'd0);
      check("ex_sum_ed", 32'(sum_a), 32'd0);
      check("ex_max_ed", 32'(max_a), 32'd0);
      repeat (3) @(negedge clk);
      check("ex_done_pulses", 32'(done_cnt_a), 32'd1);
      check("ex_sb_left", 32'(sb.size()), 32'd0);
      check("ex_frozen", 32'(seen_a), 32'd4096);
   endtask

   // Scoreboard monitor for the default instance.
   int unsigned last_seen = 0;
   always @(negedge clk) begin
      met_t e;
      if (rst) begin
         last_seen = 0;
      end else if (32'(seen_a) != last_seen) begin
         last_seen = 32'(seen_a);
         if (seen_a != 0) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_empty: n_seen %0d with no expected entry", seen_a);
            end else begin
               e = sb.pop_front();
               check("sb_n_seen", 32'(seen_a), 32'(e.seen));
               check("sb_n_err", 32'(err_a), 32'(e.err));
               check("sb_sum_ed", 32'(sum_a), 32'(e.sum));
               check("sb_max_ed", 32'(max_a), 32'(e.max));
            end
         end
      end
      if (done_a) done_cnt_a++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      dvec_t vec[8];
      vec[0] = '{6'd3,  6'd3,  12'd8,    12'd9,    12'd1};
      vec[1] = '{6'd63, 6'd63, 12'd0,    12'd3969, 12'd3969};
      vec[2] = '{6'd2,  6'd5,  12'd10,   12'd10,   12'd0};
      vec[3] = '{6'd0,  6'd63, 12'd100,  12'd0,    12'd100};
      vec[4] = '{6'd7,  6'd9,  12'd70,   12'd63,   12'd7};
      vec[5] = '{6'd63, 6'd1,  12'd4095, 12'd63,   12'd4032};
      vec[6] = '{6'd10, 6'd10, 12'd100,  12'd100,  12'd0};
      vec[7] = '{6'd32, 6'd32, 12'd0,    12'd1024, 12'd1024};
      model_clear();

      for (int i = 0; i < 8; i++) begin
         d_a = vec[i].a; d_b = vec[i].b; d_p = vec[i].p;
         #1;
         check("dist_exact", 32'(d_exact), 32'(vec[i].exact));
         check("dist_ed", 32'(d_ed), 32'(vec[i].ed));
      end

      repeat (3) @(negedge clk);
      check("rst_n_seen", 32'(seen_a), 32'd0);
      check("rst_n_err", 32'(err_a), 32'd0);
      check("rst_sum_ed", 32'(sum_a), 32'd0);
      check("rst_max_ed", 32'(max_a), 32'd0);
      check("rst_ready_busy_done", {29'd0, rdy_a, busy_a, done_a}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Exhaustive exact loopback.
      exhaustive_run();

      // Single sample with N_SAMPLES=1: latency, drain length and done pulse.
      pulse(1);
      check("n1_ready", 32'(rdy_n), 32'd1);
      in_a = 6'd3; in_b = 6'd3; approx_p = 12'd8; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("n1_ready_after", 32'(rdy_n), 32'd0);
      check("n1_seen_t0", 32'(seen_n), 32'd0);
      @(negedge clk);
      check("n1_seen_t1", 32'(seen_n), 32'd0);
      check("n1_busy_t1", 32'(busy_n), 32'd1);
      @(negedge clk);
      check("n1_seen_t2", 32'(seen_n), 32'd1);
      check("n1_err", 32'(err_n), 32'd1);
      check("n1_sum", 32'(sum_n), 32'd1);
      check("n1_max", 32'(max_n), 32'd1);
      check("n1_done_t2", 32'(done_n), 32'd0);
      @(negedge clk);
      check("n1_done_t3", 32'(done_n), 32'd1);
      @(negedge clk);
      check("n1_done_t4", 32'(done_n), 32'd0);
      check("n1_busy_t4", 32'(busy_n), 32'd0);

      // Maximum error distance.
      pulse(2);
      drive(2, 6'd63, 6'd63, 12'd0);
      drive(2, 6'd2, 6'd5, 12'd10);
      drive(2, 6'd1, 6'd1, 12'd1);
      drive(2, 6'd0, 6'd0, 12'd0);
      in_valid = 1'b0;
      wait_done(2, 20);
      check("mx_max", 32'(max_b), 32'd3969);
      check("mx_sum", 32'(sum_b), 32'd3969);
      check("mx_err", 32'(err_b), 32'd1);
      check("mx_seen", 32'(seen_b), 32'd4);

      // Saturating sum with SUM_W=12.
      pulse(3);
      drive(3, 6'd63, 6'd63, 12'd969);
      drive(3, 6'd50, 6'd60, 12'd0);
      in_valid = 1'b0;
      wait_done(3, 20);
      check("sat_sum", 32'(sum_c), 32'd4095);
      check("sat_err", 32'(err_c), 32'd2);
      check("sat_max", 32'(max_c), 32'd3000);
      check("sat_seen", 32'(seen_c), 32'd2);

      // Throttled input with an ignored start during RUN.
      pulse(2);
      drive(2, 6'd1, 6'd2, 12'd2);
      in_valid = 1'b0;
      @(negedge clk);
      pulse(2);
      check("thr_busy", 32'(busy_b), 32'd1);
      check("thr_seen_kept", 32'(seen_b), 32'd1);
      drive(2, 6'd3, 6'd4, 12'd13);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      drive(2, 6'd5, 6'd5, 12'd20);
      drive(2, 6'd6, 6'd6, 12'd36);
      check("thr_ready_drop", 32'(rdy_b), 32'd0);
      in_valid = 1'b0;
      wait_done(2, 20);
      check("thr_seen", 32'(seen_b), 32'd4);
      check("thr_err", 32'(err_b), 32'd2);
      check("thr_sum", 32'(sum_b), 32'd6);
      check("thr_max", 32'(max_b), 32'd5);

      // Reset mid-run, then a clean exhaustive run.
      model_clear();
      pulse(0);
      for (int i = 0; i < 100; i++)
         drive(0, 6'(i), 6'(i + 7), 12'(i));
      #2 rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check("mid_rst_seen", 32'(seen_a), 32'd0);
      check("mid_rst_err", 32'(err_a), 32'd0);
      check("mid_rst_sum", 32'(sum_a), 32'd0);
      check("mid_rst_max", 32'(max_a), 32'd0);
      check("mid_rst_flags", {29'd0, rdy_a, busy_a, done_a}, 32'd0);
      sb.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      exhaustive_run();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
